// File: rtl/seg7_scan_pkg.sv
// seg7_scan_pkg
// Shared definitions for the four-digit multiplexed seven-segment driver:
//   - active-high glyph constants, bit order {g,f,e,d,c,b,a}
//   - digit count
//   - shadow frame type
//   - gap counter width helper
//   - digit blanking/suppression rule
package seg7_scan_pkg;

  localparam int DIGITS = 4;

  localparam logic [6:0] GLYPH_0 = 7'b0111111;
  localparam logic [6:0] GLYPH_1 = 7'b0000110;
  localparam logic [6:0] GLYPH_2 = 7'b1011011;
  localparam logic [6:0] GLYPH_3 = 7'b1001111;
  localparam logic [6:0] GLYPH_4 = 7'b1100110;
  localparam logic [6:0] GLYPH_5 = 7'b1101101;
  localparam logic [6:0] GLYPH_6 = 7'b1111101;
  localparam logic [6:0] GLYPH_7 = 7'b0000111;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1101111;
  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_B = 7'b1111100;
  localparam logic [6:0] GLYPH_C = 7'b0111001;
  localparam logic [6:0] GLYPH_D = 7'b1011110;
  localparam logic [6:0] GLYPH_E = 7'b1111001;
  localparam logic [6:0] GLYPH_F = 7'b1110001;

  typedef logic [1:0] digit_idx_t;

  // One coherent frame of display data, captured at the start of each scan.
  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lzs;
  } frame_t;

  // Width of the anti-ghosting gap counter; never narrower than one bit.
  function automatic int gap_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

  // A digit is dark when masked, or when leading-zero suppression is on and
  // this nibble and every nibble above it are zero. Digit 0 always shows.
  function automatic logic digit_dark(input frame_t f, input digit_idx_t i);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (k >= int'(i) && f.value[4*k +: 4] != 4'h0) begin
        upper_zero = 1'b0;
      end
    end
    return f.blank[i] || (f.lzs && (i != 2'd0) && upper_zero);
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// seg7_scan_if
// Display bus between a data source and the scan driver.
//   en         display enable
//   value      four hex nibbles, digit 0 rightmost
//   dp_in      decimal point request per digit
//   blank_mask force digit dark
//   lzs        leading-zero suppression enable
//   an/seg/dp  board-side anode, segment and decimal point drives
// master: data source side; slave: the seg7_scan driver.
interface seg7_scan_if;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic        lzs;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output en, value, dp_in, blank_mask, lzs,
    input  an, seg, dp
  );

  modport slave (
    input  en, value, dp_in, blank_mask, lzs,
    output an, seg, dp
  );
endinterface

// File: rtl/seg7_scan_hex_to_seg.sv
// hex_to_seg
// Combinational hex nibble to active-high seven-segment glyph.
//   nibble  4-bit hex digit
//   glyph   segments {g,f,e,d,c,b,a}, 1 = lit
module hex_to_seg
  import seg7_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_0;
    unique case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan
// Four-digit multiplexed seven-segment driver stepped by a slow divided
// clock that is sampled as data.
//   clk       system clock
//   rst       synchronous active-low reset
//   scan_clk  divided scan clock, asynchronous to clk
//   bus       seg7_scan_if.slave: en/value/dp_in/blank_mask/lzs in,
//             an/seg/dp out (all registered)
// Parameters: GAP_CYCLES all-off cycles after each digit change,
//             ACTIVE_LOW output polarity.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int GAP_CYCLES = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_clk,
  seg7_scan_if.slave bus
);

  localparam int GW = gap_width(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
  localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = ACTIVE_LOW;

  logic          s1, s2, s3;
  logic          armed;
  logic          tick;

  digit_idx_t    idx, idx_next;
  logic [GW-1:0] gap, gap_next;
  frame_t        frame, frame_next, live;
  logic          running, running_next;

  logic [3:0]    nibble;
  logic [6:0]    glyph;
  logic          lit;
  logic [3:0]    an_on;
  logic [6:0]    seg_on;
  logic          dp_on;

  // Synchroniser plus edge flop. On the first cycle after reset release the
  // whole chain is preloaded with the current scan_clk level, so a level that
  // was already high through reset is not mistaken for a fresh rising edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      armed <= 1'b0;
    end else if (!armed) begin
      s1    <= scan_clk;
      s2    <= scan_clk;
      s3    <= scan_clk;
      armed <= 1'b1;
    end else begin
      s1 <= scan_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

  assign live = {bus.value, bus.dp_in, bus.blank_mask, bus.lzs};

  // Scan sequencing. While disabled the shadow frame tracks the inputs and
  // the index parks at 3, so the first tick after enabling starts a fresh
  // frame on digit 0. 'running' keeps the display dark until that first tick.
  always_comb begin
    idx_next     = idx;
    gap_next     = gap;
    frame_next   = frame;
    running_next = running;
    if (!bus.en) begin
      idx_next     = 2'd3;
      gap_next     = '0;
      frame_next   = live;
      running_next = 1'b0;
    end else if (tick) begin
      idx_next     = idx + 2'd1;
      gap_next     = GAP_LOAD;
      running_next = 1'b1;
      if (idx == 2'd3) begin
        frame_next = live;
      end
    end else if (gap != '0) begin
      gap_next = gap - GW'(1);
    end
  end

  // Outputs are decoded from next-state values so that the registered
  // drives line up with the state they describe on the same edge.
  assign nibble = frame_next.value[{idx_next, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .glyph  (glyph)
  );

  always_comb begin
    lit    = running_next && (gap_next == '0) && !digit_dark(frame_next, idx_next);
    an_on  = 4'h0;
    seg_on = 7'h00;
    dp_on  = 1'b0;
    if (lit) begin
      an_on  = 4'b0001 << idx_next;
      seg_on = glyph;
      dp_on  = frame_next.dp[idx_next];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx     <= 2'd3;
      gap     <= '0;
      frame   <= '0;
      running <= 1'b0;
      bus.an  <= AN_OFF;
      bus.seg <= SEG_OFF;
      bus.dp  <= DP_OFF;
    end else begin
      idx     <= idx_next;
      gap     <= gap_next;
      frame   <= frame_next;
      running <= running_next;
      bus.an  <= ACTIVE_LOW ? ~an_on  : an_on;
      bus.seg <= ACTIVE_LOW ? ~seg_on : seg_on;
      bus.dp  <= ACTIVE_LOW ? ~dp_on  : dp_on;
    end
  end

endmodule
